// File: rtl/posit_encode_pipe_es3.sv
`timescale 1ns/1ps
// posit_encode_pipe_es3: 3-stage posit encoder (ES=3) packing sign/scale/fraction into a posit word.
// Define POSIT_ENC_RNE_EN for round-to-nearest-even; without it the body is truncated.
module posit_encode_pipe_es3 #(
    parameter int NBITS = 32,
    parameter int ES    = 3,
    parameter int FBITS = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sgn,
    input  logic [8:0]       in_scale,
    input  logic [FBITS-1:0] in_fraction,
    input  logic             in_sticky,
    input  logic             in_zero,
    input  logic             in_inf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_posit,
    output logic             out_inf,
    output logic             out_zero
);
    // Wide enough that the longest regime shift never pushes body bits off the bottom.
    localparam int VW        = 2 + ES + FBITS + NBITS - 1;
    localparam int SCALE_MAX = (NBITS - 2) << ES;
    localparam logic [NBITS-2:0] MAXPOS = '1;
    localparam logic [NBITS-2:0] MINPOS = {{(NBITS-2){1'b0}}, 1'b1};

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic signed [8:0] scale_s;
    logic signed [8:0] k;
    logic [8:0]        sh_next;
    logic              sat_hi_next;
    logic              sat_lo_next;

    // For k<0 the shift is -k-1, which is just ~k in two's complement.
    always_comb begin
        scale_s     = $signed(in_scale);
        k           = scale_s >>> ES;
        sh_next     = k[8] ? ~k : k;
        sat_hi_next = scale_s > $signed(9'(SCALE_MAX));
        sat_lo_next = scale_s < -$signed(9'(SCALE_MAX));
    end

    logic             s1_valid;
    logic             s1_sgn;
    logic             s1_neg;
    logic [8:0]       s1_sh;
    logic [ES-1:0]    s1_exp;
    logic [FBITS-1:0] s1_frac;
    logic             s1_sticky;
    logic             s1_zero;
    logic             s1_inf;
    logic             s1_sat_hi;
    logic             s1_sat_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sgn    <= 1'b0;
            s1_neg    <= 1'b0;
            s1_sh     <= '0;
            s1_exp    <= '0;
            s1_frac   <= '0;
            s1_sticky <= 1'b0;
            s1_zero   <= 1'b0;
            s1_inf    <= 1'b0;
            s1_sat_hi <= 1'b0;
            s1_sat_lo <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sgn    <= in_sgn;
                s1_neg    <= k[8];
                s1_sh     <= sh_next;
                s1_exp    <= in_scale[ES-1:0];
                s1_frac   <= in_fraction;
                s1_sticky <= in_sticky;
                s1_zero   <= in_zero;
                s1_inf    <= in_inf;
                s1_sat_hi <= sat_hi_next;
                s1_sat_lo <= sat_lo_next;
            end
        end
    end

    logic signed [VW-1:0] packed_s;
    logic signed [VW-1:0] shifted;
    logic [NBITS-2:0]     body_next;
    logic                 guard_next;
    logic                 sticky_next;

    // Arithmetic shift of the "10"/"01" head replicates the leading regime bit k times.
    always_comb begin
        packed_s    = {~s1_neg, s1_neg, s1_exp, s1_frac, {(NBITS-1){1'b0}}};
        shifted     = packed_s >>> s1_sh;
        body_next   = shifted[VW-1 -: NBITS-1];
        guard_next  = shifted[VW-NBITS];
        sticky_next = (|shifted[VW-NBITS-1:0]) | s1_sticky;
        if (s1_sat_hi) begin
            body_next   = MAXPOS;
            guard_next  = 1'b0;
            sticky_next = 1'b0;
        end else if (s1_sat_lo) begin
            body_next   = MINPOS;
            guard_next  = 1'b0;
            sticky_next = 1'b0;
        end
    end

    logic             s2_valid;
    logic             s2_sgn;
    logic [NBITS-2:0] s2_body;
    logic             s2_guard;
    logic             s2_sticky;
    logic             s2_zero;
    logic             s2_inf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_sgn    <= 1'b0;
            s2_body   <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_zero   <= 1'b0;
            s2_inf    <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sgn    <= s1_sgn;
                s2_body   <= body_next;
                s2_guard  <= guard_next;
                s2_sticky <= sticky_next;
                s2_zero   <= s1_zero;
                s2_inf    <= s1_inf;
            end
        end
    end

    logic             round_up;
    logic [NBITS-1:0] mag;
    logic [NBITS-1:0] result;

    always_comb begin
`ifdef POSIT_ENC_RNE_EN
        round_up = s2_guard & (s2_sticky | s2_body[0]);
`else
        round_up = 1'b0;
`endif
        mag = {1'b0, s2_body} + {{(NBITS-1){1'b0}}, round_up};
        // A carry into the sign position would alias NaR; a zero body would alias zero.
        if (mag[NBITS-1]) begin
            mag = {1'b0, MAXPOS};
        end else if (mag == '0) begin
            mag = {1'b0, MINPOS};
        end
        result = s2_sgn ? -mag : mag;
        if (s2_inf) begin
            result = {1'b1, {(NBITS-1){1'b0}}};
        end else if (s2_zero) begin
            result = '0;
        end
    end

`ifndef POSIT_ENC_RNE_EN
    logic unused_rnd;
    assign unused_rnd = s2_guard ^ s2_sticky;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_posit <= '0;
            out_inf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_posit <= result;
                out_inf   <= s2_inf;
                out_zero  <= ~s2_inf & s2_zero;
            end
        end
    end

endmodule

// File: tb/tb_posit_encode_pipe_es3.sv
`timescale 1ns/1ps
// tb_posit_encode_pipe_es3: table of encode vectors fed through a scoreboard, plus latency,
// output-stall and mid-flight reset sequences. Expected values follow POSIT_ENC_RNE_EN.
module tb_posit_encode_pipe_es3;

    typedef struct {
        string       name;
        logic        sgn;
        logic [8:0]  scale;
        logic [27:0] frac;
        logic        sticky;
        logic        zero;
        logic        inf;
        logic [31:0] posit;
        logic        exp_inf;
        logic        exp_zero;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] posit;
        logic        inf;
        logic        zero;
    } exp_t;

`ifdef POSIT_ENC_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sgn;
    logic [8:0]  in_scale;
    logic [27:0] in_fraction;
    logic        in_sticky;
    logic        in_zero;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_posit;
    logic        out_inf;
    logic        out_zero;

    always #5 clk = ~clk;

    posit_encode_pipe_es3 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sgn     (in_sgn),
        .in_scale   (in_scale),
        .in_fraction(in_fraction),
        .in_sticky  (in_sticky),
        .in_zero    (in_zero),
        .in_inf     (in_inf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_posit  (out_posit),
        .out_inf    (out_inf),
        .out_zero   (out_zero)
    );

    exp_t        sb[$];
    vec_t        vecs[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          out_count  = 0;
    int          c0;
    int          lat;
    logic [31:0] held;

    function automatic vec_t mk(string name, logic sgn, int scale, logic [27:0] frac, logic sticky,
                                logic zero, logic inf, logic [31:0] posit, logic einf, logic ezero);
        vec_t v;
        v.name = name; v.sgn = sgn; v.scale = 9'(scale); v.frac = frac; v.sticky = sticky;
        v.zero = zero; v.inf = inf; v.posit = posit; v.exp_inf = einf; v.exp_zero = ezero;
        return v;
    endfunction

    function automatic exp_t expOf(vec_t v);
        exp_t e;
        e.name = v.name; e.posit = v.posit; e.inf = v.exp_inf; e.zero = v.exp_zero;
        return e;
    endfunction

    task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(exp_t e);
        checkValue({e.name, " posit"}, out_posit, e.posit);
        checkValue({e.name, " inf"}, {31'b0, out_inf}, {31'b0, e.inf});
        checkValue({e.name, " zero"}, {31'b0, out_zero}, {31'b0, e.zero});
    endtask

    // Scoreboard side: a result leaves the DUT on the next edge when valid and ready at negedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            out_count++;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected output: got 0x%08h, expected none", out_posit);
            end else begin
                checkOutput(sb.pop_front());
            end
        end
    end

    task automatic driveInputs(vec_t v);
        in_valid    = 1'b1;
        in_sgn      = v.sgn;
        in_scale    = v.scale;
        in_fraction = v.frac;
        in_sticky   = v.sticky;
        in_zero     = v.zero;
        in_inf      = v.inf;
    endtask

    task automatic applyStimulus(vec_t v);
        int waited = 0;
        @(posedge clk);
        #1;
        driveInputs(v);
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept timeout %s: got in_ready=0, expected 1", v.name);
        end else begin
            sb.push_back(expOf(v));
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checkValue({name, " drained"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_sgn = 1'b0; in_scale = '0; in_fraction = '0;
        in_sticky = 1'b0; in_zero = 1'b0; in_inf = 1'b0; out_ready = 1'b1;

        vecs.push_back(mk("one",         0,    0, 28'h0,       0, 0, 0, 32'h40000000, 0, 0));
        vecs.push_back(mk("minus_one",   1,    0, 28'h0,       0, 0, 0, 32'hC0000000, 0, 0));
        vecs.push_back(mk("scale8",      0,    8, 28'h0,       0, 0, 0, 32'h60000000, 0, 0));
        vecs.push_back(mk("scale_m1",    0,   -1, 28'h0,       0, 0, 0, 32'h3C000000, 0, 0));
        vecs.push_back(mk("sat_250",     0,  250, 28'h0,       0, 0, 0, 32'h7FFFFFFF, 0, 0));
        vecs.push_back(mk("sat_m256",    0, -256, 28'h0,       0, 0, 0, 32'h00000001, 0, 0));
        vecs.push_back(mk("neg_minpos",  1, -256, 28'h0,       0, 0, 0, 32'hFFFFFFFF, 0, 0));
        vecs.push_back(mk("neg_maxpos",  1,  250, 28'h0,       0, 0, 0, 32'h80000001, 0, 0));
        vecs.push_back(mk("tie_even",    0,    0, 28'h2,       0, 0, 0, 32'h40000000, 0, 0));
        vecs.push_back(mk("tie_odd",     0,    0, 28'h6,       0, 0, 0,
                          RNE ? 32'h40000002 : 32'h40000001, 0, 0));
        vecs.push_back(mk("above_half",  0,    0, 28'h2,       1, 0, 0,
                          RNE ? 32'h40000001 : 32'h40000000, 0, 0));
        vecs.push_back(mk("nar_prio",    0,    0, 28'h0,       0, 1, 1, 32'h80000000, 1, 0));
        vecs.push_back(mk("zero",        0,    0, 28'h0,       0, 1, 0, 32'h00000000, 0, 1));
        vecs.push_back(mk("maxpos_240",  0,  240, 28'h0,       0, 0, 0, 32'h7FFFFFFF, 0, 0));
        vecs.push_back(mk("sat_241",     0,  241, 28'h0,       0, 0, 0, 32'h7FFFFFFF, 0, 0));
        vecs.push_back(mk("minpos_m240", 0, -240, 28'h0,       0, 0, 0, 32'h00000001, 0, 0));
        vecs.push_back(mk("sat_m241",    0, -241, 28'h0,       0, 0, 0, 32'h00000001, 0, 0));
        vecs.push_back(mk("round_239",   0,  239, 28'h0,       0, 0, 0,
                          RNE ? 32'h7FFFFFFF : 32'h7FFFFFFE, 0, 0));
        vecs.push_back(mk("neg_round",   1,    0, 28'h6,       0, 0, 0,
                          RNE ? 32'hBFFFFFFE : 32'hBFFFFFFF, 0, 0));
        vecs.push_back(mk("scale1_half", 0,    1, 28'h8000000, 0, 0, 0, 32'h46000000, 0, 0));
        vecs.push_back(mk("scale_m9",    0,   -9, 28'h0,       0, 0, 0, 32'h1E000000, 0, 0));
        vecs.push_back(mk("nar_neg",     1,    5, 28'h0,       0, 0, 1, 32'h80000000, 1, 0));
        vecs.push_back(mk("zero_neg",    1,  200, 28'hFFFFFFF, 1, 1, 0, 32'h00000000, 0, 1));

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset out_valid", {31'b0, out_valid}, 32'h0);
        checkValue("reset out_posit", out_posit, 32'h0);
        checkValue("reset out_inf", {31'b0, out_inf}, 32'h0);
        checkValue("reset out_zero", {31'b0, out_zero}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("reset in_ready", {31'b0, in_ready}, 32'h1);

        // Latency: count edges from acceptance until out_valid rises.
        @(posedge clk);
        #1;
        driveInputs(vecs[0]);
        sb.push_back(expOf(vecs[0]));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkValue("latency", lat, 3);
        waitDrain("latency");

        foreach (vecs[i]) applyStimulus(vecs[i]);
        idle();
        waitDrain("table");

        // Stream of 8 with a 3-cycle consumer stall once the pipe is full.
        c0 = out_count;
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checkValue("stall in_ready", {31'b0, in_ready}, 32'h0);
                    checkValue("stall out_valid", {31'b0, out_valid}, 32'h1);
                    if (c == 0) held = out_posit;
                    else checkValue("stall hold", out_posit, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain("stream");
        checkValue("stream count", out_count - c0, 8);

        // Reset with two beats in flight, the older one already presented.
        c0 = out_count;
        applyStimulus(vecs[2]);
        applyStimulus(vecs[3]);
        idle();
        @(posedge clk);
        #2;
        checkValue("pre-reset out_valid", {31'b0, out_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkValue("mid reset out_valid", {31'b0, out_valid}, 32'h0);
        checkValue("mid reset out_posit", out_posit, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("post reset in_ready", {31'b0, in_ready}, 32'h1);
        repeat (6) @(posedge clk);
        #1;
        checkValue("no stale beats", out_count - c0, 0);
        checkValue("post reset out_valid", {31'b0, out_valid}, 32'h0);
        applyStimulus(vecs[4]);
        idle();
        waitDrain("after reset");
        checkValue("after reset count", out_count - c0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
